// File: rtl/line_window_3x3.sv
// line_window_3x3
// Buffers two image lines of a raster-order pixel stream and presents every
// complete 3x3 neighbourhood (no padding) as nine parallel pixels with a
// one-cycle valid strobe. Pixel data passes through bit-exact.
module line_window_3x3 #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic signed [DATA_W-1:0] pix_in,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic                     win_valid,
  output logic                     frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_ZERO = '0;
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = '0;
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   col_reg, col_next;
  logic [RW-1:0]   row_reg, row_next;
  logic            emit_next;
  logic            last_next;
  logic [CW-1:0]   col_eff;

  // Two line buffers: lb0 holds the previous line, lb1 the one before that.
  // Read is asynchronous so the new window column is available the same cycle.
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];

  // Shift window: sh_reg[row][pos], row 0 = oldest line, pos 2 = newest column.
  logic [DATA_W-1:0] sh_reg [3][3];
  // Incoming right-hand column, top to bottom.
  logic [DATA_W-1:0] new_col [3];

  // Registered output window in row-major order.
  logic [DATA_W-1:0] out_reg [9];
  logic              win_valid_reg;
  logic              frame_done_reg;

  // A start-of-frame pixel always lands in column 0, whatever the counters say.
  assign col_eff = pix_sof ? COL_ZERO : col_reg;

  assign new_col[0] = lb1_mem[col_eff];
  assign new_col[1] = lb0_mem[col_eff];
  assign new_col[2] = pix_in;

  // Position counters and fill/run state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      col_reg   <= COL_ZERO;
      row_reg   <= ROW_ZERO;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  // Next position, state transitions and emit/frame-end decisions.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    emit_next  = 1'b0;
    last_next  = 1'b0;
    if (pix_valid) begin
      if (pix_sof) begin
        // Restart: this pixel is (0,0); anything buffered is abandoned.
        state_next = FILL;
        col_next   = COL_ONE;
        row_next   = ROW_ZERO;
      end else begin
        // A window completes only once two earlier columns of this line exist.
        emit_next = (state_reg == RUN) && (col_reg >= COL_TWO);
        last_next = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
        if (col_reg == COL_LAST) begin
          col_next = COL_ZERO;
          row_next = (row_reg == ROW_LAST) ? ROW_ZERO : row_reg + ROW_ONE;
        end else begin
          col_next = col_reg + COL_ONE;
        end
        if ((state_reg == FILL) && (row_reg == ROW_ONE) && (col_reg == COL_LAST)) begin
          state_next = RUN;
        end
        if (last_next) begin
          state_next = FILL;
        end
      end
    end
  end

  // Line buffer update: the previous line ages into lb1, the new pixel into lb0.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[col_eff] <= lb0_mem[col_eff];
      lb0_mem[col_eff] <= pix_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rows
      // Shift this window row left by one column on every accepted pixel.
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_reg[gi][0] <= '0;
          sh_reg[gi][1] <= '0;
          sh_reg[gi][2] <= '0;
        end else if (pix_valid) begin
          sh_reg[gi][0] <= sh_reg[gi][1];
          sh_reg[gi][1] <= sh_reg[gi][2];
          sh_reg[gi][2] <= new_col[gi];
        end
      end

      // Capture the completed window row (post-shift contents) when emitting.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg[3*gi+0] <= '0;
          out_reg[3*gi+1] <= '0;
          out_reg[3*gi+2] <= '0;
        end else if (emit_next) begin
          out_reg[3*gi+0] <= sh_reg[gi][1];
          out_reg[3*gi+1] <= sh_reg[gi][2];
          out_reg[3*gi+2] <= new_col[gi];
        end
      end
    end
  endgenerate

  // One-cycle strobes for a new window and for the end of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      win_valid_reg  <= emit_next;
      frame_done_reg <= last_next;
    end
  end

  assign win0       = out_reg[0];
  assign win1       = out_reg[1];
  assign win2       = out_reg[2];
  assign win3       = out_reg[3];
  assign win4       = out_reg[4];
  assign win5       = out_reg[5];
  assign win6       = out_reg[6];
  assign win7       = out_reg[7];
  assign win8       = out_reg[8];
  assign win_valid  = win_valid_reg;
  assign frame_done = frame_done_reg;

endmodule
